// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings and field widths for the IF-stage branch predictor (bpu_pkg).
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_e;

  localparam cnt_e ALLOC_CNT = WT;

  localparam int BPU_IDX_W = 6;
  localparam int BPU_TAG_W = 8;
  localparam int BPU_TGT_W = 32;
  localparam int BPU_CNT_W = 2;

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// Pure 2-bit saturating up/down counter step used by the predictor write stage.
module sat_counter2
  import bpu_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  output logic [1:0] cnt_o
);

  // next counter value: +1 when taken, -1 when not, clamped at both ends
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != ST) begin
        cnt_o = cnt_i + 2'd1;
      end else begin
        cnt_o = cnt_i;
      end
    end else begin
      if (cnt_i != SNT) begin
        cnt_o = cnt_i - 2'd1;
      end else begin
        cnt_o = cnt_i;
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: zero-cycle lookup, two-stage training.
// Optional resolved-branch/mispredict statistics enabled by defining BPU_STATS_EN.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int         IDX_W    = BPU_IDX_W,
  parameter int         TAG_W    = BPU_TAG_W,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic [31:0] bpu_pred_pc,
  output logic        bpu_pred_taken,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
`ifdef BPU_STATS_EN
  input  logic        bpu_write_en,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`else
  input  logic        bpu_write_en
`endif
);

  localparam int ENTRIES = 1 << IDX_W;

  logic                 valid_q [ENTRIES];
  logic                 valid_d [ENTRIES];
  logic [1:0]           cnt_q   [ENTRIES];
  logic [1:0]           cnt_d   [ENTRIES];
  logic [TAG_W-1:0]     tag_q   [ENTRIES];
  logic [TAG_W-1:0]     tag_d   [ENTRIES];
  logic [BPU_TGT_W-1:0] tgt_q   [ENTRIES];
  logic [BPU_TGT_W-1:0] tgt_d   [ENTRIES];

  logic                 u_vld_q,    u_vld_d;
  logic [IDX_W-1:0]     u_idx_q,    u_idx_d;
  logic [TAG_W-1:0]     u_tag_q,    u_tag_d;
  logic                 u_taken_q,  u_taken_d;
  logic [BPU_TGT_W-1:0] u_target_q, u_target_d;

  logic [IDX_W-1:0]     lk_idx_s;
  logic [TAG_W-1:0]     lk_tag_s;
  logic                 lk_hit_s;
  logic                 wr_hit_s;
  logic [1:0]           wr_cnt_s;
  logic                 unused_s;

  assign lk_idx_s = if_pc[IDX_W+1:2];
  assign lk_tag_s = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit_s = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);

  // lookup: predicted next PC for the fetch mux
  always_comb begin
    bpu_pred_taken = lk_hit_s && cnt_q[lk_idx_s][1];
    if (bpu_pred_taken) begin
      bpu_pred_pc = tgt_q[lk_idx_s];
    end else begin
      bpu_pred_pc = if_pc + 32'd4;
    end
  end

  // capture stage: latch the resolved branch for next cycle's read-modify-write
  always_comb begin
    u_vld_d    = upd_en;
    u_idx_d    = upd_pc[IDX_W+1:2];
    u_tag_d    = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    u_taken_d  = upd_taken;
    u_target_d = upd_target;
  end

  // capture-stage registers; reset drops any in-flight update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_vld_q    <= 1'b0;
      u_idx_q    <= '0;
      u_tag_q    <= '0;
      u_taken_q  <= 1'b0;
      u_target_q <= 32'd0;
    end else begin
      u_vld_q    <= u_vld_d;
      u_idx_q    <= u_idx_d;
      u_tag_q    <= u_tag_d;
      u_taken_q  <= u_taken_d;
      u_target_q <= u_target_d;
    end
  end

  // Reads the live table, so back-to-back updates to one index chain correctly.
  assign wr_hit_s = valid_q[u_idx_q] && (tag_q[u_idx_q] == u_tag_q);

  sat_counter2 u_sat (
    .cnt_i (cnt_q[u_idx_q]),
    .inc_i (u_taken_q),
    .cnt_o (wr_cnt_s)
  );

  // write stage: train on hit, allocate on taken miss, ignore not-taken miss
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (u_vld_q) begin
      if (wr_hit_s) begin
        cnt_d[u_idx_q] = wr_cnt_s;
        if (u_taken_q) begin
          tgt_d[u_idx_q] = u_target_q;
        end else begin
          tgt_d[u_idx_q] = tgt_q[u_idx_q];
        end
      end else if (u_taken_q) begin
        valid_d[u_idx_q] = 1'b1;
        tag_d[u_idx_q]   = u_tag_q;
        tgt_d[u_idx_q]   = u_target_q;
        cnt_d[u_idx_q]   = ALLOC_CNT;
      end else begin
        valid_d[u_idx_q] = valid_q[u_idx_q];
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // table state that takes the reset: valid bits and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_INIT;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // tags and targets are never reset; valid gates their use
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q,  stat_mispred_d;

  // free-running statistics, wrapping at 32 bits
  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (upd_en) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (bpu_write_en) begin
        stat_mispred_d = stat_mispred_q + 32'd1;
      end else begin
        stat_mispred_d = stat_mispred_q;
      end
    end else begin
      stat_branches_d = stat_branches_q;
    end
  end

  // statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= 32'd0;
      stat_mispred_q  <= 32'd0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
  assign unused_s = ^{upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0]};
`else
  assign unused_s = ^{upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0], bpu_write_en};
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (stats checks when BPU_STATS_EN is defined).
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic [31:0] bpu_pred_pc;
  logic        bpu_pred_taken;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        bpu_write_en;
`ifdef BPU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  branch_predict_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .bpu_pred_pc    (bpu_pred_pc),
    .bpu_pred_taken (bpu_pred_taken),
    .upd_en         (upd_en),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
`ifdef BPU_STATS_EN
    .bpu_write_en   (bpu_write_en),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
`else
    .bpu_write_en   (bpu_write_en)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one resolved branch for one cycle; returns 1ns after the capturing edge
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic we);
    upd_en       = 1'b1;
    upd_pc       = pc;
    upd_taken    = tk;
    upd_target   = tgt;
    bpu_write_en = we;
    @(posedge clk);
    #1;
    upd_en       = 1'b0;
    bpu_write_en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] pc, input logic [31:0] exp_pc, input logic exp_tk);
    if_pc = pc;
    #1;
    n_asrt++;
    assert (bpu_pred_pc === exp_pc) else begin
      n_fail++;
      $error("FAIL %s pred_pc: observed %h expected %h", tag, bpu_pred_pc, exp_pc);
    end
    n_asrt++;
    assert (bpu_pred_taken === exp_tk) else begin
      n_fail++;
      $error("FAIL %s pred_taken: observed %b expected %b", tag, bpu_pred_taken, exp_tk);
    end
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 32'h8000_0000; upd_en = 1'b0; upd_pc = 32'd0;
    upd_taken = 1'b0; upd_target = 32'd0; bpu_write_en = 1'b0;
    tick();
    chk("rst_in_reset", 32'h8000_0000, 32'h8000_0004, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rst_seq", 32'h8000_0000, 32'h8000_0004, 1'b0);
    chk("rst_wrap", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);

    // allocate idx 4 / tag 0x00; change visible two edges after upd_en
    upd(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0);
    chk("alloc_n1_old", 32'h8000_0010, 32'h8000_0014, 1'b0);
    tick();
    chk("alloc_n2_new", 32'h8000_0010, 32'h8000_0100, 1'b1);
    chk("alloc_other_idx", 32'h8000_0020, 32'h8000_0024, 1'b0);

    // counter 2->1 (then 1->0 back to back)
    upd(32'h8000_0010, 1'b0, 32'h0000_0000, 1'b0);
    upd(32'h8000_0010, 1'b0, 32'h0000_0000, 1'b0);
    chk("nt1_cnt1", 32'h8000_0010, 32'h8000_0014, 1'b0);
    tick();
    chk("nt2_cnt0", 32'h8000_0010, 32'h8000_0014, 1'b0);

    // 0->1->2->3->3, then one not-taken must leave 2 (taken)
    upd(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0);
    upd(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0);
    upd(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0);
    upd(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0);
    tick();
    chk("sat_cnt3", 32'h8000_0010, 32'h8000_0100, 1'b1);
    upd(32'h8000_0010, 1'b0, 32'h0000_0000, 1'b0);
    tick();
    chk("sat_dec_to2", 32'h8000_0010, 32'h8000_0100, 1'b1);
    upd(32'h8000_0010, 1'b0, 32'h0000_0000, 1'b0);
    tick();
    chk("dec_to1", 32'h8000_0010, 32'h8000_0014, 1'b0);

    // alias: same idx, tag 0x01 replaces the entry
    upd(32'h8000_0110, 1'b1, 32'h8000_0200, 1'b0);
    tick();
    chk("alias_new", 32'h8000_0110, 32'h8000_0200, 1'b1);
    chk("alias_old_miss", 32'h8000_0010, 32'h8000_0014, 1'b0);

    // not-taken miss writes nothing: aliased entry keeps counter 2
    upd(32'h8000_0010, 1'b0, 32'h0000_0000, 1'b0);
    tick();
    chk("nt_miss_nowrite", 32'h8000_0110, 32'h8000_0200, 1'b1);
    chk("nt_miss_still_miss", 32'h8000_0010, 32'h8000_0014, 1'b0);

    // reset in cycle N+1 discards the captured update and clears the table
    upd(32'h8000_0040, 1'b1, 32'h8000_0400, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk("rst_inflight_drop", 32'h8000_0040, 32'h8000_0044, 1'b0);
    chk("rst_clears_alias", 32'h8000_0110, 32'h8000_0114, 1'b0);

`ifdef BPU_STATS_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    n_asrt++;
    assert (stat_branches === 32'd0) else begin
      n_fail++;
      $error("FAIL stat_rst_br: observed %h expected %h", stat_branches, 32'd0);
    end
    upd(32'h8000_0080, 1'b1, 32'h8000_0800, 1'b1);
    upd(32'h8000_0084, 1'b0, 32'h0000_0000, 1'b0);
    upd(32'h8000_0088, 1'b1, 32'h8000_0900, 1'b1);
    upd(32'h8000_008C, 1'b0, 32'h0000_0000, 1'b0);
    upd(32'h8000_0090, 1'b0, 32'h0000_0000, 1'b0);
    bpu_write_en = 1'b1;
    tick();
    bpu_write_en = 1'b0;
    n_asrt++;
    assert (stat_branches === 32'd5) else begin
      n_fail++;
      $error("FAIL stat_branches: observed %0d expected %0d", stat_branches, 5);
    end
    n_asrt++;
    assert (stat_mispred === 32'd2) else begin
      n_fail++;
      $error("FAIL stat_mispred: observed %0d expected %0d", stat_mispred, 2);
    end
    force dut.stat_branches_q = 32'hFFFF_FFFF;
    force dut.stat_mispred_q  = 32'hFFFF_FFFF;
    #1;
    release dut.stat_branches_q;
    release dut.stat_mispred_q;
    upd(32'h8000_0094, 1'b0, 32'h0000_0000, 1'b1);
    n_asrt++;
    assert (stat_branches === 32'd0) else begin
      n_fail++;
      $error("FAIL stat_br_wrap: observed %h expected %h", stat_branches, 32'd0);
    end
    n_asrt++;
    assert (stat_mispred === 32'd0) else begin
      n_fail++;
      $error("FAIL stat_mp_wrap: observed %h expected %h", stat_mispred, 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
